// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC level decoder.
// Escape prefixes, suffix adaptation thresholds and the FSM state encoding live here.
package cavlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_T1    = 2'd1,
    ST_LEVEL = 2'd2
  } state_e;

  typedef logic signed [15:0] level_t;
  typedef logic [15:0]        code_t;

  localparam int unsigned PREFIX_W       = 16;
  localparam logic [3:0]  ESC_PREFIX_14  = 4'd14;
  localparam logic [3:0]  ESC_PREFIX_15  = 4'd15;
  localparam logic [3:0]  ESC14_SUFFIX_W = 4'd4;
  localparam logic [3:0]  ESC_SUFFIX_W   = 4'd12;
  localparam logic [2:0]  SUFFIX_LEN_MAX = 3'd6;

  localparam code_t THR_SL1 = 16'd3;
  localparam code_t THR_SL2 = 16'd6;
  localparam code_t THR_SL3 = 16'd12;
  localparam code_t THR_SL4 = 16'd24;
  localparam code_t THR_SL5 = 16'd48;

  // Magnitude above which the suffix length grows: 3 << (sl - 1).
  function automatic code_t suffix_thresh(input logic [2:0] sl);
    code_t thr;
    case (sl)
      3'd1:    thr = THR_SL1;
      3'd2:    thr = THR_SL2;
      3'd3:    thr = THR_SL3;
      3'd4:    thr = THR_SL4;
      default: thr = THR_SL5;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/level_prefix_finder.sv
// Leading-zero count of a 16-bit MSB-first field; found_o is low when the field is all zeros.
// Purely combinational.
module level_prefix_finder (
  input  logic [15:0] bits_i,
  output logic [3:0]  prefix_o,
  output logic        found_o
);

  // Ascending scan: the highest set bit is the last one written.
  always_comb begin
    prefix_o = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (bits_i[i]) prefix_o = 4'(15 - i);
    end
    found_o = |bits_i;
  end

endmodule

// File: rtl/cavlc_level_decoder.sv
// CAVLC level decoder: trailing-one signs then prefix/suffix levels, one coefficient per cycle, LevelValid one cycle after issue.
// Backpressure: while LevelValid && !LevelReady the output register holds and no bitstream is consumed.
module cavlc_level_decoder
  import cavlc_pkg::*;
#(
  parameter int WIN_W     = 32,
  parameter int MAX_COEFF = 16,
  parameter int LEVEL_W   = 16
) (
  input  logic                           Clk,
  input  logic                           nReset,
  input  logic                           Start,
  input  logic [$clog2(MAX_COEFF+1)-1:0] TotalCoeff,
  input  logic [1:0]                     TrailingOnes,
  input  logic [WIN_W-1:0]               Window,
  output logic [4:0]                     NumShift,
  output logic                           ShiftEn,
  output logic [LEVEL_W-1:0]             LevelOut,
  output logic [$clog2(MAX_COEFF)-1:0]   LevelIdx,
  output logic                           LevelValid,
  input  logic                           LevelReady,
  output logic                           Done,
  output logic                           Error,
  output logic                           Busy
);

  localparam int TC_W  = $clog2(MAX_COEFF + 1);
  localparam int IDX_W = $clog2(MAX_COEFF);

  state_e             state_q, state_d;
  logic [TC_W-1:0]    tc_q, tc_d;
  logic [TC_W-1:0]    cnt_q, cnt_d;
  logic [1:0]         t1_q, t1_d;
  logic [2:0]         sl_q, sl_d;
  logic               first_q, first_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done0_q, done0_d;
  logic               err_q, err_d;

  logic [3:0]  prefix;
  logic        found;
  logic [3:0]  sfx_size;
  logic [11:0] sfx_field;
  code_t       sfx_val;
  code_t       lvl_code;
  code_t       lvl_abs;
  level_t      lvl_dec;
  logic [2:0]  sl_base;
  logic [2:0]  sl_next;
  logic [4:0]  lvl_bits;

  logic can_issue, issue, lvl_err, is_last, t1_end;
  logic start_acc, start_bad;

  level_prefix_finder u_prefix (
    .bits_i   (Window[WIN_W-1 -: PREFIX_W]),
    .prefix_o (prefix),
    .found_o  (found)
  );

  assign can_issue = !vld_q || LevelReady;
  assign issue     = can_issue && ((state_q == ST_T1) || ((state_q == ST_LEVEL) && found));
  assign lvl_err   = can_issue && (state_q == ST_LEVEL) && !found;
  assign is_last   = (cnt_q == (tc_q - TC_W'(1)));
  assign t1_end    = (cnt_q == (TC_W'(t1_q) - TC_W'(1)));
  assign start_acc = (state_q == ST_IDLE) && Start && !vld_q;
  assign start_bad = TC_W'(TrailingOnes) > TotalCoeff;

  // Level decode of the codeword at the top of the window.
  always_comb begin
    sfx_size = {1'b0, sl_q};
    if (prefix == ESC_PREFIX_15) begin
      sfx_size = ESC_SUFFIX_W;
    end else if ((prefix == ESC_PREFIX_14) && (sl_q == 3'd0)) begin
      sfx_size = ESC14_SUFFIX_W;
    end
    // Suffix starts right after the prefix's terminating one.
    sfx_field = 12'(Window >> (WIN_W - 13 - int'(prefix)));
    sfx_val   = code_t'(sfx_field >> (4'd12 - sfx_size));

    lvl_code = (code_t'(prefix) << sl_q) + sfx_val;
    if ((prefix == ESC_PREFIX_15) && (sl_q == 3'd0)) lvl_code = lvl_code + code_t'(ESC_PREFIX_15);
    if (first_q && (t1_q != 2'd3)) lvl_code = lvl_code + 16'd2;

    if (!lvl_code[0]) begin
      lvl_abs = (lvl_code + 16'd2) >> 1;
      lvl_dec = $signed(lvl_abs);
    end else begin
      lvl_abs = (lvl_code + 16'd1) >> 1;
      lvl_dec = -$signed(lvl_abs);
    end

    sl_base = (sl_q == 3'd0) ? 3'd1 : sl_q;
    sl_next = sl_base;
    if ((lvl_abs > suffix_thresh(sl_base)) && (sl_base < SUFFIX_LEN_MAX)) sl_next = sl_base + 3'd1;

    lvl_bits = {1'b0, prefix} + 5'd1 + {1'b0, sfx_size};
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc && !start_bad && (TotalCoeff != '0)) begin
          state_d = (TrailingOnes == 2'd0) ? ST_LEVEL : ST_T1;
        end
      end
      ST_T1: begin
        if (issue) begin
          if (is_last)     state_d = ST_IDLE;
          else if (t1_end) state_d = ST_LEVEL;
        end
      end
      ST_LEVEL: begin
        if (lvl_err || (issue && is_last)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ShiftEn  = issue;
    NumShift = 5'd0;
    if (issue) NumShift = (state_q == ST_T1) ? 5'd1 : lvl_bits;
    Done       = done0_q | (vld_q & LevelReady & last_q);
    Error      = err_q;
    Busy       = (state_q != ST_IDLE) | vld_q;
    LevelValid = vld_q;
    LevelOut   = lvl_q;
    LevelIdx   = idx_q;
  end

  always_comb begin
    tc_d    = tc_q;
    t1_d    = t1_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    first_d = first_q;
    vld_d   = vld_q;
    last_d  = last_q;
    lvl_d   = lvl_q;
    idx_d   = idx_q;
    done0_d = 1'b0;
    err_d   = 1'b0;

    if (vld_q && LevelReady) vld_d = 1'b0;

    if (start_acc) begin
      if (start_bad) begin
        err_d = 1'b1;
      end else begin
        tc_d    = TotalCoeff;
        t1_d    = TrailingOnes;
        sl_d    = ((TotalCoeff > TC_W'(10)) && (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
        cnt_d   = '0;
        first_d = 1'b1;
        done0_d = (TotalCoeff == '0);
      end
    end

    if (lvl_err) begin
      err_d = 1'b1;
      vld_d = 1'b0;
    end

    if (issue) begin
      vld_d  = 1'b1;
      last_d = is_last;
      idx_d  = IDX_W'(cnt_q);
      cnt_d  = cnt_q + TC_W'(1);
      if (state_q == ST_T1) begin
        lvl_d = Window[WIN_W-1] ? {LEVEL_W{1'b1}} : LEVEL_W'(1);
      end else begin
        lvl_d   = LEVEL_W'(lvl_dec);
        sl_d    = sl_next;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      tc_q    <= '0;
      t1_q    <= '0;
      cnt_q   <= '0;
      sl_q    <= '0;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      lvl_q   <= '0;
      idx_q   <= '0;
      done0_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tc_q    <= tc_d;
      t1_q    <= t1_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      first_q <= first_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      lvl_q   <= lvl_d;
      idx_q   <= idx_d;
      done0_q <= done0_d;
      err_q   <= err_d;
    end
  end

endmodule
